// File: rtl/gamepad_pmod_tx.sv
// Gamepad PMOD link transmitter: snapshots two 12-bit controller states and
// shifts them out MSB first on pmod_clk/pmod_data, then strobes pmod_latch.
module gamepad_pmod_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] buttons_p1,
  input  logic [11:0] buttons_p2,
  input  logic        start,
  output logic        pmod_clk,
  output logic        pmod_data,
  output logic        pmod_latch,
  output logic        busy,
  output logic        done
);

  // Request semantics: start is a level sampled only while idle; while busy it
  // is ignored and never queued. Holding it high yields back-to-back frames
  // separated by the single done cycle.

  localparam int DW = $clog2(2 * CLK_DIV + 1);

  localparam logic [DW-1:0] HALF_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] LATCH_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);
  localparam logic [4:0]    LAST_BIT   = 5'd23;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_LATCH    = 2'd3;

  logic [1:0]    state,   state_nxt;
  logic [23:0]   shreg,   shreg_nxt;
  logic [4:0]    bit_cnt, bit_cnt_nxt;
  logic [DW-1:0] div_cnt, div_cnt_nxt;

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_SHIFT_LO;
          shreg_nxt   = {buttons_p1, buttons_p2};
          bit_cnt_nxt = '0;
          div_cnt_nxt = '0;
        end
      end
      ST_SHIFT_LO: begin
        if (div_cnt == HALF_LAST) begin
          div_cnt_nxt = '0;
          state_nxt   = ST_SHIFT_HI;
        end else begin
          div_cnt_nxt = div_cnt + DIV_ONE;
        end
      end
      ST_SHIFT_HI: begin
        if (div_cnt == HALF_LAST) begin
          div_cnt_nxt = '0;
          shreg_nxt   = {shreg[22:0], 1'b0};
          bit_cnt_nxt = bit_cnt + 5'd1;
          state_nxt   = (bit_cnt == LAST_BIT) ? ST_LATCH : ST_SHIFT_LO;
        end else begin
          div_cnt_nxt = div_cnt + DIV_ONE;
        end
      end
      ST_LATCH: begin
        if (div_cnt == LATCH_LAST) begin
          div_cnt_nxt = '0;
          state_nxt   = ST_IDLE;
        end else begin
          div_cnt_nxt = div_cnt + DIV_ONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      div_cnt <= div_cnt_nxt;
    end
  end

  // Outputs are flopped from the next-state values so they line up with the
  // state register while never depending combinationally on the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmod_clk   <= 1'b0;
      pmod_data  <= 1'b0;
      pmod_latch <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      pmod_clk   <= (state_nxt == ST_SHIFT_HI);
      pmod_data  <= ((state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI)) && shreg_nxt[23];
      pmod_latch <= (state_nxt == ST_LATCH);
      busy       <= (state_nxt != ST_IDLE);
      done       <= (state == ST_LATCH) && (state_nxt == ST_IDLE);
    end
  end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Self-checking bench for gamepad_pmod_tx: table vectors, random frames, and
// hand-written sequences (mid-frame input change, ignored start, back-to-back, reset abort).
module tb_gamepad_pmod_tx;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [11:0] p1_a = '0, p2_a = '0, p1_b = '0, p2_b = '0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic        pclk_a, pdata_a, platch_a, busy_a, done_a;
  logic        pclk_b, pdata_b, platch_b, busy_b, done_b;

  gamepad_pmod_tx #(.CLK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .buttons_p1(p1_a), .buttons_p2(p2_a), .start(start_a),
    .pmod_clk(pclk_a), .pmod_data(pdata_a), .pmod_latch(platch_a), .busy(busy_a), .done(done_a)
  );

  gamepad_pmod_tx #(.CLK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .buttons_p1(p1_b), .buttons_p2(p2_b), .start(start_b),
    .pmod_clk(pclk_b), .pmod_data(pdata_b), .pmod_latch(platch_b), .busy(busy_b), .done(done_b)
  );

  typedef struct packed {
    logic pclk;
    logic pdata;
    logic platch;
    logic busy;
    logic done;
  } out_t;

  typedef struct {
    logic [11:0] p1;
    logic [11:0] p2;
    logic [23:0] frame;
  } vec_t;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [23:0] exp_q[$];

  logic [23:0] rx_sr;
  int rx_bits, busy_cnt, latch_cnt, done_cnt, overlap_cnt, wave_err;
  logic prev_pclk, prev_latch;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clear_stats();
    rx_sr = '0; rx_bits = 0; busy_cnt = 0; latch_cnt = 0; done_cnt = 0;
    overlap_cnt = 0; wave_err = 0; prev_pclk = 1'b0; prev_latch = 1'b0;
  endtask

  // Bench-side receiver: shifts pmod_data on pmod_clk rises, compares on latch.
  task automatic observe(input out_t o);
    if (o.pclk && !prev_pclk) begin
      rx_sr = {rx_sr[22:0], o.pdata};
      rx_bits++;
    end
    if (o.platch && !prev_latch) begin
      check("rx_bit_count", rx_bits, 24);
      if (exp_q.size() == 0) check("rx_unexpected_frame", rx_sr, 24'hxxxxxx);
      else check("rx_frame", rx_sr, exp_q.pop_front());
      rx_bits = 0;
    end
    if (o.pclk && o.platch) overlap_cnt++;
    busy_cnt  += int'(o.busy);
    latch_cnt += int'(o.platch);
    done_cnt  += int'(o.done);
    prev_pclk  = o.pclk;
    prev_latch = o.platch;
  endtask

  // Reference waveform: k = cycles after the edge that sampled start.
  function automatic out_t model(input int k, input logic [23:0] frame, input int cd);
    out_t o;
    o = '0;
    if (k < 48 * cd) begin
      o.busy  = 1'b1;
      o.pclk  = (k % (2 * cd)) >= cd;
      o.pdata = frame[23 - k / (2 * cd)];
    end else if (k < 50 * cd) begin
      o.busy   = 1'b1;
      o.platch = 1'b1;
    end else if (k == 50 * cd) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic out_t sample_a();
    return '{pclk_a, pdata_a, platch_a, busy_a, done_a};
  endfunction

  function automatic out_t sample_b();
    return '{pclk_b, pdata_b, platch_b, busy_b, done_b};
  endfunction

  // ---------------- driver tasks ----------------
  // One CLK_DIV=4 frame; optional mid-frame button change and extra start pulses.
  task automatic run_frame_a(input logic [11:0] p1, input logic [11:0] p2,
                             input int chg_k, input int ign1, input int ign2);
    logic [23:0] frame;
    out_t o;
    frame = {p1, p2};
    clear_stats();
    exp_q.push_back(frame);
    @(negedge clk);
    p1_a = p1; p2_a = p2; start_a = 1'b1;
    for (int k = 0; k <= 204; k++) begin
      @(negedge clk);
      o = sample_a();
      observe(o);
      if (o !== model(k, frame, 4)) wave_err++;
      start_a = (k == ign1) || (k == ign2);
      if (k == chg_k) begin
        p1_a = 12'hFFF; p2_a = 12'hFFF;
      end
    end
    start_a = 1'b0;
    check("a_waveform_errors", wave_err, 0);
    check("a_busy_cycles", busy_cnt, 200);
    check("a_latch_cycles", latch_cnt, 8);
    check("a_done_pulses", done_cnt, 1);
    check("a_clk_latch_overlap", overlap_cnt, 0);
    check("a_frames_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  vec_t vecs[5];

  initial begin
    out_t o;
    vecs[0] = '{12'hA5C, 12'h3F1, 24'hA5C3F1};
    vecs[1] = '{12'h000, 12'h000, 24'h000000};
    vecs[2] = '{12'hFFF, 12'hFFF, 24'hFFFFFF};
    vecs[3] = '{12'h800, 12'h001, 24'h800001};
    vecs[4] = '{12'h555, 12'hAAA, 24'h555AAA};

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("reset_outputs_a", sample_a(), '0);
    check("reset_outputs_b", sample_b(), '0);
    rst_n = 1'b1;
    wave_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sample_a() !== '0 || sample_b() !== '0) wave_err++;
    end
    check("idle_after_reset", wave_err, 0);

    // Table vectors: the received frame must equal the table's expected word.
    for (int i = 0; i < 5; i++) begin
      clear_stats();
      exp_q.push_back(vecs[i].frame);
      @(negedge clk);
      p1_a = vecs[i].p1; p2_a = vecs[i].p2; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check("tbl_first_data", pdata_a, vecs[i].p1[11]);
      check("tbl_busy_start", busy_a, 1);
      for (int k = 1; k <= 202; k++) begin
        @(negedge clk);
        observe(sample_a());
      end
      check("tbl_rx_done", done_cnt, 1);
      check("tbl_frames_pending", exp_q.size(), 0);
      exp_q.delete();
    end

    // Full waveform check on the spec example, with inputs changed at bit 5.
    run_frame_a(12'hA5C, 12'h3F1, -1, -1, -1);
    run_frame_a(12'hA5C, 12'h3F1, 40, -1, -1);
    // start pulses while busy must be ignored.
    run_frame_a(12'h3C3, 12'h0F0, -1, 10, 150);

    // Random frames against the model.
    for (int i = 0; i < 4; i++)
      run_frame_a(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), -1, -1, -1);

    // Back-to-back frames on the CLK_DIV=1 instance with start held high.
    begin
      logic [23:0] cur;
      int last_done;
      int frames;
      clear_stats();
      frames = 0;
      last_done = -1;
      @(negedge clk);
      p1_b = 12'($urandom_range(0, 4095)); p2_b = 12'($urandom_range(0, 4095));
      start_b = 1'b1;
      cur = {p1_b, p2_b};
      exp_q.push_back(cur);
      for (int k = 0; k < 51 * 4 + 3; k++) begin
        @(negedge clk);
        o = sample_b();
        observe(o);
        if (k >= 51 * 4) begin
          if (o !== '0) wave_err++;
        end else if (o !== model(k % 51, cur, 1)) wave_err++;
        if (o.done) begin
          if (last_done >= 0) check("b2b_done_period", k - last_done, 51);
          last_done = k;
        end
        if (k % 51 == 50) begin
          frames++;
          if (frames < 4) begin
            p1_b = 12'($urandom_range(0, 4095)); p2_b = 12'($urandom_range(0, 4095));
            cur = {p1_b, p2_b};
            exp_q.push_back(cur);
          end else begin
            start_b = 1'b0;
          end
        end
      end
      check("b2b_waveform_errors", wave_err, 0);
      check("b2b_done_pulses", done_cnt, 4);
      check("b2b_busy_cycles", busy_cnt, 200);
      check("b2b_frames_pending", exp_q.size(), 0);
      exp_q.delete();
    end

    // Reset during bit 12 aborts the frame without latch or done.
    clear_stats();
    @(negedge clk);
    p1_a = 12'h9C6; p2_a = 12'h1E7; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (12 * 8 + 3) @(negedge clk);
    check("pre_reset_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", sample_a(), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    for (int k = 0; k < 220; k++) begin
      @(negedge clk);
      observe(sample_a());
    end
    check("abort_no_latch", latch_cnt, 0);
    check("abort_no_done", done_cnt, 0);
    check("abort_no_busy", busy_cnt, 0);
    run_frame_a(12'h9C6, 12'h1E7, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
